// File: rtl/scmem_pkg.sv
// ============================================================================
// Module : scmem_pkg
// Brief  : Shared constants and types for the scmem_io data-memory stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package scmem_pkg;

    localparam logic [3:0] IO_PAGE   = 4'hF;

    localparam logic [1:0] UART_TX   = 2'd0;
    localparam logic [1:0] UART_STAT = 2'd1;
    localparam logic [1:0] TIMER     = 2'd2;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/scmem_io_if.sv
// ============================================================================
// Module : scmem_io_if
// Brief  : CPU data-side bus (address, store data, write strobe, load data).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface scmem_io_if;
    logic [31:0] addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;

    modport master (output addr, output datain, output we, input dataout);
    modport slave  (input addr, input datain, input we, output dataout);
endinterface

`default_nettype wire

// File: rtl/scmem_io_uart_tx.sv
// ============================================================================
// Module : uart_tx
// Brief  : Buffered 8N1 UART transmitter: TX FIFO, serializer, sticky overflow.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx
    import scmem_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic       clock,
    input  wire logic       reset,
    input  wire logic       push,
    input  wire logic [7:0] push_data,
    input  wire logic       clr_ovf,
    output logic      [7:0] status,
    output logic            tx,
    output logic            tx_busy
);

    localparam int            PW      = $clog2(FIFO_DEPTH);
    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] C_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   C_DEPTH = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [PW:0]   r_cnt;
    logic          r_ovf;

    ser_state_t    r_state;
    ser_state_t    w_state_nx;
    logic [CW-1:0] r_clk_cnt;
    logic [CW-1:0] w_clk_nx;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nx;
    logic [7:0]    r_sh;
    logic [7:0]    w_sh_nx;

    logic w_full;
    logic w_empty;
    logic w_push_ok;
    logic w_pop;
    logic w_tick;

    assign w_full    = (r_cnt == C_DEPTH);
    assign w_empty   = (r_cnt == '0);
    assign w_push_ok = push & ~w_full;
    assign w_tick    = (r_clk_cnt == C_LAST);

    always_ff @(posedge clock) begin
        if (w_push_ok) begin
            r_fifo[r_wr] <= push_data;
        end
    end

    // A push into a full FIFO is dropped even if a pop frees a slot this edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + (PW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (PW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            if (push && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_clk_cnt <= '0;
            r_bit     <= '0;
            r_sh      <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_clk_cnt <= w_clk_nx;
            r_bit     <= w_bit_nx;
            r_sh      <= w_sh_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_clk_nx   = r_clk_cnt;
        w_bit_nx   = r_bit;
        w_sh_nx    = r_sh;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop      = 1'b1;
                    w_sh_nx    = r_fifo[r_rd];
                    w_clk_nx   = '0;
                    w_state_nx = START;
                end
            end
            START: begin
                if (w_tick) begin
                    w_clk_nx   = '0;
                    w_bit_nx   = '0;
                    w_state_nx = DATA;
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            DATA: begin
                if (w_tick) begin
                    w_clk_nx = '0;
                    w_sh_nx  = {1'b0, r_sh[7:1]};
                    if (r_bit == 3'd7) begin
                        w_state_nx = STOP;
                    end else begin
                        w_bit_nx = r_bit + 3'd1;
                    end
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit so frames stay contiguous.
                if (w_tick) begin
                    w_clk_nx = '0;
                    if (!w_empty) begin
                        w_pop      = 1'b1;
                        w_sh_nx    = r_fifo[r_rd];
                        w_state_nx = START;
                    end else begin
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_clk_nx = r_clk_cnt + CW'(1);
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign tx      = (r_state == START) ? 1'b0 :
                     (r_state == DATA)  ? r_sh[0] : 1'b1;
    assign tx_busy = (r_state != IDLE) | ~w_empty;

    always_comb begin
        status                       = '0;
        status[STAT_FULL]            = w_full;
        status[STAT_EMPTY]           = w_empty;
        status[STAT_BUSY]            = tx_busy;
        status[STAT_OVF]             = r_ovf;
        status[STAT_CNT_LSB +: 4]    = 4'(r_cnt);
    end

endmodule

`default_nettype wire

// File: rtl/scmem_io.sv
// ============================================================================
// Module : scmem_io
// Brief  : CPU data memory stage: word RAM plus I/O page (UART TX, timer).
//          Define SCMEM_TIMER_EN to include the free-running TIMER register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module scmem_io
    import scmem_pkg::*;
#(
    parameter int RAM_AW       = 10,
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic  clock,
    input  wire logic  reset,
    scmem_io_if.slave  bus,
    output logic       tx,
    output logic       tx_busy
);

    logic [31:0]       r_mem [2**RAM_AW];
    logic              w_io_sel;
    logic [1:0]        w_reg;
    logic [RAM_AW-1:0] w_word;
    logic              w_ram_we;
    logic              w_push;
    logic              w_clr_ovf;
    logic [7:0]        w_status;
    logic [31:0]       w_timer;
    logic [31:0]       w_rdata;
    logic              w_unused_addr;

    assign w_io_sel      = (bus.addr[31:28] == IO_PAGE);
    assign w_reg         = bus.addr[3:2];
    assign w_word        = bus.addr[RAM_AW+1:2];
    assign w_ram_we      = bus.we & ~w_io_sel;
    assign w_push        = bus.we & w_io_sel & (w_reg == UART_TX);
    assign w_clr_ovf     = bus.we & w_io_sel & (w_reg == UART_STAT);
    assign w_unused_addr = ^bus.addr;

    // Upper address bits are not decoded, so RAM aliases across the low space.
    always_ff @(posedge clock) begin
        if (w_ram_we) begin
            r_mem[w_word] <= bus.datain;
        end
    end

`ifdef SCMEM_TIMER_EN
    logic [31:0] r_timer;
    logic        w_tmr_we;

    assign w_tmr_we = bus.we & w_io_sel & (w_reg == TIMER);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_tmr_we) begin
            r_timer <= bus.datain;
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    assign w_timer = r_timer;
`else
    assign w_timer = '0;
`endif

    uart_tx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) u_uart_tx (
        .clock     (clock),
        .reset     (reset),
        .push      (w_push),
        .push_data (bus.datain[7:0]),
        .clr_ovf   (w_clr_ovf),
        .status    (w_status),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    always_comb begin
        w_rdata = '0;
        if (w_io_sel) begin
            case (w_reg)
                UART_STAT: w_rdata = {24'b0, w_status};
                TIMER:     w_rdata = w_timer;
                default:   w_rdata = '0;
            endcase
        end else begin
            w_rdata = r_mem[w_word];
        end
    end

    assign bus.dataout = w_rdata;

endmodule

`default_nettype wire

// File: doc/scmem_io.md
Name: scmem_io

Overview:
- Data-side memory stage for the single-cycle CPU: consumes the CPU's ALU result (address), store data and write-memory strobe; returns load data in the same cycle.
- Decodes a word-addressed data RAM plus a memory-mapped I/O page holding a buffered 8N1 UART transmitter and a free-running cycle timer.
- Sits directly downstream of the CPU datapath; its dataout drives the CPU's memory-data input.

Parameters:
- RAM_AW, 10, word-address width of the data RAM (depth 2**RAM_AW words).
- CLKS_PER_BIT, 16, clock cycles per UART bit; must be at least 2.
- FIFO_DEPTH, 4, UART TX FIFO entries; must be a power of two, at least 2.

Ports:
- clock  in  1  system clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- addr  in  32  byte address (CPU ALU result); addr[1:0] ignored.
- datain  in  32  store data (CPU register rt value).
- we  in  1  write enable (CPU wmem).
- dataout  out  32  load data, combinational from addr and current state.
- tx  out  1  UART serial output, idle high.
- tx_busy  out  1  high while the serializer is not IDLE or the FIFO is non-empty.

Behaviour:
- Decode: addr[31:28]==4'hF selects I/O; otherwise RAM at word index addr[RAM_AW+1:2]. Upper RAM address bits are ignored (aliasing).
- RAM: combinational read; write of the full 32-bit word on the rising edge when we=1. Contents are not affected by reset.
- I/O map (addr[3:2]):
  - 0 UART_TX: write pushes datain[7:0]; reads 0.
  - 1 UART_STAT: read {24'b0, cnt[3:0], ovf, busy, empty, full}; any write clears ovf.
  - 2 TIMER: reads count; write loads datain.
  - 3 reserved: reads 0, writes ignored.
- Reset values: tx=1, tx_busy=0, FIFO empty (cnt=0), ovf=0, TIMER=0, serializer IDLE.
- FIFO:
  - Push on a write to UART_TX. A push while full (sampled before the edge) is dropped and sets sticky ovf, even if a pop occurs on the same edge.
  - Pop occurs when the serializer is IDLE and the FIFO is non-empty.
  - Simultaneous push and pop when not full: cnt is unchanged and both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
- Serializer FSM:
  - IDLE -> START on pop, latching the byte.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB-first, CLKS_PER_BIT cycles each; 3-bit bit counter -> STOP after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE, or START directly if the FIFO is non-empty, so there is no idle gap between bytes.
- UART latency: a write at edge N into an empty FIFO with the serializer IDLE gives a pop at edge N+1; tx falls after N+1. One frame is 10*CLKS_PER_BIT cycles.
- Timer: increments by 1 each cycle and wraps 0xFFFFFFFF -> 0. On a write cycle the loaded value replaces the increment.
- Reset asserted mid-frame: tx returns high immediately; the FIFO and frame are discarded.

Optional Feature:
- SCMEM_TIMER_EN.
- Defined: TIMER register present as above.
- Undefined: no counter logic; TIMER reads 0 and writes are ignored.
- The UART and RAM are unaffected either way.

Decomposition:
- Package scmem_pkg:
  - I/O page nibble 4'hF.
  - Register offsets UART_TX=2'd0, UART_STAT=2'd1, TIMER=2'd2.
  - STAT bit positions FULL=0, EMPTY=1, BUSY=2, OVF=3, CNT=7:4.
  - Serializer state enum {IDLE, START, DATA, STOP}.
- Sub-module uart_tx: FIFO, serializer, ovf and status. Ports: clock, reset, push, push_data[7:0], clr_ovf, status[7:0], tx, tx_busy.
- The top level keeps the RAM, decode, timer and read mux.

Test Plan:
- Reset, then read addr 0xF0000004 -> 0x00000002 (empty only); tx=1; tx_busy=0.
- Write 0x12345678 to 0x00000010, then read 0x00000010 -> 0x12345678. Read 0x00001010 with RAM_AW=10 -> 0x12345678 (alias).
- Write 0xA5 to 0xF0000000, CLKS_PER_BIT=16:
  - tx low from edge 2 for 16 cycles;
  - then bits 1,0,1,0,0,1,0,1 at 16 cycles each;
  - then stop high;
  - tx_busy falls 160 cycles after tx fell.
- Five back-to-back writes 0x01..0x05 while IDLE:
  - byte 0x01 pops, 0x02..0x05 fill the FIFO, no ovf;
  - a sixth write sets STAT bit3;
  - frames are contiguous;
  - a write to STAT clears ovf.
- With SCMEM_TIMER_EN: write 0xFFFFFFFE to 0xF0000008, then read 0xFFFFFFFE, 0xFFFFFFFF and 0x00000000 on successive cycles. Without it: read 0.
- Assert reset mid-DATA of a frame with 2 bytes queued: tx=1 immediately; STAT reads 0x00000002 after release; no further frames are sent.
